// File: rtl/padrao_serial_pkg.sv
// rtl/padrao_serial_pkg.sv - shared FSM state type and idle level for the serial pattern generator
// The PARITY state exists only when GERA_PADRAO_PARITY_EN is defined.
package padrao_serial_pkg;

`ifdef GERA_PADRAO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_e;
`endif

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/shift_reg_piso.sv
// rtl/shift_reg_piso.sv - parallel-in serial-out data register, shifts left, MSB first
// msb_d is the MSB the register will hold after this edge, so the caller can register it.
module shift_reg_piso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb_d
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_d = data_d[WIDTH-1];

endmodule

// File: rtl/gera_padrao_serial.sv
// rtl/gera_padrao_serial.sv - serializes a WIDTH-bit word MSB first with a done pulse
// Optional even-parity trailer cycle when GERA_PADRAO_PARITY_EN is defined.
module gera_padrao_serial
  import padrao_serial_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x_out,
  output logic             tx_active,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          x_out_q, x_out_d;
  logic          tx_q, tx_d;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;
  logic          accept;
  logic          sr_shift;
  logic          sr_msb_d;
`ifdef GERA_PADRAO_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign accept   = valid_in & rdy_q;
  assign sr_shift = (state_q == ST_SHIFT) && (cnt_q != '0);

  shift_reg_piso #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst_n (reset),
    .load  (accept),
    .shift (sr_shift),
    .din   (data_in),
    .msb_d (sr_msb_d)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_out_d  = x_out_q;
    tx_d     = tx_q;
    rdy_d    = rdy_q;
    done_d   = 1'b0;
`ifdef GERA_PADRAO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        x_out_d = IDLE_LEVEL;
        tx_d    = 1'b0;
        rdy_d   = 1'b1;
        if (accept) begin
          state_d  = ST_SHIFT;
          cnt_d    = CW'(WIDTH - 1);
          x_out_d  = sr_msb_d;
          tx_d     = 1'b1;
          rdy_d    = 1'b0;
`ifdef GERA_PADRAO_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
          x_out_d = sr_msb_d;
        end else begin
`ifdef GERA_PADRAO_PARITY_EN
          state_d = ST_PARITY;
          x_out_d = parity_q;
`else
          state_d = ST_IDLE;
          x_out_d = IDLE_LEVEL;
          tx_d    = 1'b0;
          rdy_d   = 1'b1;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef GERA_PADRAO_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
        x_out_d = IDLE_LEVEL;
        tx_d    = 1'b0;
        rdy_d   = 1'b1;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        x_out_d = IDLE_LEVEL;
        tx_d    = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  // ready stays low during reset and rises on the first edge after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_out_q  <= IDLE_LEVEL;
      tx_q     <= 1'b0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef GERA_PADRAO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_out_q  <= x_out_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
`ifdef GERA_PADRAO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign x_out     = x_out_q;
  assign tx_active = tx_q;
  assign ready_out = rdy_q;
  assign done      = done_q;

endmodule
